// File: rtl/jk_pkg.sv
// Shared definitions for JK-cell based counters and dividers.
//   DIR_DOWN / DIR_UP : encoding of the direction input.
//   mod_next          : next value of a modulo-N up/down count, computed in
//                       the widest supported count width (16 bits). The
//                       modulus is 17 bits wide so that 2^16 is representable.
package jk_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int MAX_WIDTH = 16;

  // The increment is taken only below the last value, and the decrement only
  // above zero, so no intermediate ever leaves the range 0..modulus-1. That
  // also makes modulus = 2^width wrap without needing a carry bit.
  function automatic logic [15:0] mod_next(input logic [15:0] count,
                                           input logic        up,
                                           input logic [16:0] modulus);
    logic [16:0] last;
    last = modulus - 17'd1;
    if (up == DIR_UP) begin
      if ({1'b0, count} == last) mod_next = 16'd0;
      else                       mod_next = count + 16'd1;
    end else begin
      if (count == 16'd0) mod_next = last[15:0];
      else                mod_next = count - 16'd1;
    end
  endfunction

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle of jk_sync_counter.
//   en, up, load, load_val : requests from the controlling block
//   count, tc, wrap, load_err : counter state and indications
// master = controlling block, slave = counter.
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, wrap, load_err
  );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with synchronous active-high reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces Q to 0
//   J, K  : 00 hold, 01 clear, 10 set, 11 toggle
//   Q     : registered cell output
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({J, K})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells in toggle mode.
// Each cycle the next count is computed, and the bits that differ from the
// current count are toggled through J = K = 1; all other cells hold (JK = 00).
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus.en     : step enable          bus.up       : 1 = up, 0 = down
//   bus.load   : parallel load        bus.load_val : value to load
//   bus.count  : current count        bus.tc       : terminal count (comb.)
//   bus.wrap   : one-cycle pulse after a wrapping step
//   bus.load_err : sticky, set by a load of a value >= MODULUS
// Edge priority: reset > load > en > hold.
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_sync_counter_if.slave     bus
);
  import jk_pkg::*;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || MODULUS < 2 || MODULUS > (1 << WIDTH))
  begin : g_bad_params
    $error("jk_sync_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
  localparam logic [16:0]      MOD_W = 17'(MODULUS);

  // count_q is held in the JK cells; count_d is what they must reach.
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic             tc;
  logic             wrap_q;
  logic             wrap_d;
  logic             load_err_q;
  logic             load_err_d;

  always_comb begin
    tc = ((bus.up == DIR_UP)   && (count_q == LAST)) ||
         ((bus.up == DIR_DOWN) && (count_q == '0));
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = load_err_q;
    if (bus.load) begin
      if (17'(bus.load_val) < MOD_W) begin
        count_d = bus.load_val;
      end else begin
        count_d    = LAST;
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      count_d = WIDTH'(mod_next(16'(count_q), bus.up, MOD_W));
      // An enabled step from the terminal value is exactly a wrap.
      wrap_d  = tc;
    end
  end

  assign toggle = count_q ^ count_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .J     (toggle[i]),
      .K     (toggle[i]),
      .Q     (count_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter: a WIDTH=4/MODULUS=10 instance and a
// WIDTH=3/MODULUS=8 full-range instance share clock and reset.
module tb_jk_sync_counter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  jk_sync_counter_if #(.WIDTH(4)) bus_a ();
  jk_sync_counter_if #(.WIDTH(3)) bus_b ();

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  jk_sync_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.en = 1'b1; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_val = 4'd0;
    bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.load_val = 3'd0;
    step();
    step();
    n_checks++;
    if (bus_a.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus_a.count); end
    n_checks++;
    if (bus_a.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", bus_a.wrap); end
    n_checks++;
    if (bus_a.load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b want 0", bus_a.load_err); end
    n_checks++;
    if (bus_a.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up: got %b want 0", bus_a.tc); end
    n_checks++;
    if (bus_b.count !== 3'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d want 0", bus_b.count); end
    bus_a.up = 1'b0;
    #1;
    n_checks++;
    if (bus_a.tc !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down: got %b want 1", bus_a.tc); end
    bus_a.up = 1'b1;
    bus_a.en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_up_count();
    logic [3:0] exp;
    bus_a.en = 1'b1; bus_a.up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = 4'(i % 10);
      n_checks++;
      if (bus_a.count !== exp) begin n_fail++; $display("FAIL up_count step %0d: got %0d want %0d", i, bus_a.count, exp); end
      n_checks++;
      if (bus_a.wrap !== (i == 10)) begin n_fail++; $display("FAIL up_wrap step %0d: got %b want %b", i, bus_a.wrap, (i == 10)); end
      n_checks++;
      if (bus_a.tc !== (exp == 4'd9)) begin n_fail++; $display("FAIL up_tc step %0d: got %b want %b", i, bus_a.tc, (exp == 4'd9)); end
    end
    bus_a.en = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] down_exp [4];
    down_exp = '{4'd1, 4'd0, 4'd9, 4'd8};
    bus_a.load = 1'b1; bus_a.load_val = 4'd2; bus_a.en = 1'b0;
    step();
    n_checks++;
    if (bus_a.count !== 4'd2) begin n_fail++; $display("FAIL down_load: got %0d want 2", bus_a.count); end
    n_checks++;
    if (bus_a.wrap !== 1'b0) begin n_fail++; $display("FAIL down_load_wrap: got %b want 0", bus_a.wrap); end
    bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus_a.count !== down_exp[i]) begin n_fail++; $display("FAIL down_count step %0d: got %0d want %0d", i, bus_a.count, down_exp[i]); end
      n_checks++;
      if (bus_a.wrap !== (i == 2)) begin n_fail++; $display("FAIL down_wrap step %0d: got %b want %b", i, bus_a.wrap, (i == 2)); end
      n_checks++;
      if (bus_a.tc !== (down_exp[i] == 4'd0)) begin n_fail++; $display("FAIL down_tc step %0d: got %b want %b", i, bus_a.tc, (down_exp[i] == 4'd0)); end
    end
    bus_a.en = 1'b0; bus_a.up = 1'b1;
  endtask

  task automatic test_priority();
    bus_a.load = 1'b1; bus_a.load_val = 4'd3; bus_a.en = 1'b0;
    step();
    n_checks++;
    if (bus_a.count !== 4'd3) begin n_fail++; $display("FAIL prio_setup: got %0d want 3", bus_a.count); end
    bus_a.load_val = 4'd5; bus_a.en = 1'b1; bus_a.up = 1'b1;
    step();
    n_checks++;
    if (bus_a.count !== 4'd5) begin n_fail++; $display("FAIL prio_load_over_en: got %0d want 5", bus_a.count); end
    reset = 1'b1; bus_a.load_val = 4'd12;
    step();
    n_checks++;
    if (bus_a.count !== 4'd0) begin n_fail++; $display("FAIL prio_reset_count: got %0d want 0", bus_a.count); end
    n_checks++;
    if (bus_a.load_err !== 1'b0) begin n_fail++; $display("FAIL prio_reset_load_err: got %b want 0", bus_a.load_err); end
    reset = 1'b0; bus_a.load = 1'b0; bus_a.en = 1'b0;
  endtask

  task automatic test_illegal_load();
    logic [3:0] exp;
    bus_a.load = 1'b1; bus_a.load_val = 4'd12;
    step();
    n_checks++;
    if (bus_a.count !== 4'd9) begin n_fail++; $display("FAIL illegal_count: got %0d want 9", bus_a.count); end
    n_checks++;
    if (bus_a.load_err !== 1'b1) begin n_fail++; $display("FAIL illegal_load_err: got %b want 1", bus_a.load_err); end
    n_checks++;
    if (bus_a.wrap !== 1'b0) begin n_fail++; $display("FAIL illegal_wrap: got %b want 0", bus_a.wrap); end
    bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = 4'((9 + k) % 10);
      n_checks++;
      if (bus_a.count !== exp) begin n_fail++; $display("FAIL sticky_count step %0d: got %0d want %0d", k, bus_a.count, exp); end
      n_checks++;
      if (bus_a.load_err !== 1'b1) begin n_fail++; $display("FAIL sticky_load_err step %0d: got %b want 1", k, bus_a.load_err); end
    end
    reset = 1'b1; bus_a.en = 1'b0;
    step();
    n_checks++;
    if (bus_a.load_err !== 1'b0) begin n_fail++; $display("FAIL load_err_clear: got %b want 0", bus_a.load_err); end
    reset = 1'b0;
  endtask

  task automatic test_dir_flip_hold();
    bus_a.load = 1'b1; bus_a.load_val = 4'd4; bus_a.en = 1'b0;
    step();
    bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b1;
    step();
    n_checks++;
    if (bus_a.count !== 4'd5) begin n_fail++; $display("FAIL flip_up1: got %0d want 5", bus_a.count); end
    bus_a.up = 1'b0;
    step();
    n_checks++;
    if (bus_a.count !== 4'd4) begin n_fail++; $display("FAIL flip_down: got %0d want 4", bus_a.count); end
    bus_a.up = 1'b1;
    step();
    n_checks++;
    if (bus_a.count !== 4'd5) begin n_fail++; $display("FAIL flip_up2: got %0d want 5", bus_a.count); end
    bus_a.load = 1'b1; bus_a.load_val = 4'd9; bus_a.en = 1'b0;
    step();
    bus_a.load = 1'b0;
    #1;
    n_checks++;
    if (bus_a.tc !== 1'b1) begin n_fail++; $display("FAIL tc_comb_up: got %b want 1", bus_a.tc); end
    bus_a.up = 1'b0;
    #1;
    n_checks++;
    if (bus_a.tc !== 1'b0) begin n_fail++; $display("FAIL tc_comb_down: got %b want 0", bus_a.tc); end
    bus_a.up = 1'b1; bus_a.en = 1'b1;
    step();
    n_checks++;
    if (bus_a.wrap !== 1'b1) begin n_fail++; $display("FAIL hold_pre_wrap: got %b want 1", bus_a.wrap); end
    bus_a.en = 1'b0;
    for (int h = 0; h < 3; h++) begin
      step();
      n_checks++;
      if (bus_a.count !== 4'd0) begin n_fail++; $display("FAIL hold_count cycle %0d: got %0d want 0", h, bus_a.count); end
      n_checks++;
      if (bus_a.wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap cycle %0d: got %b want 0", h, bus_a.wrap); end
    end
  endtask

  task automatic test_full_range();
    bus_b.load = 1'b1; bus_b.load_val = 3'd6; bus_b.en = 1'b0; bus_b.up = 1'b1;
    step();
    n_checks++;
    if (bus_b.count !== 3'd6) begin n_fail++; $display("FAIL full_load: got %0d want 6", bus_b.count); end
    bus_b.load = 1'b0; bus_b.en = 1'b1;
    step();
    n_checks++;
    if (bus_b.count !== 3'd7) begin n_fail++; $display("FAIL full_seven: got %0d want 7", bus_b.count); end
    n_checks++;
    if (bus_b.tc !== 1'b1) begin n_fail++; $display("FAIL full_tc: got %b want 1", bus_b.tc); end
    step();
    n_checks++;
    if ($isunknown(bus_b.count) || bus_b.count !== 3'd0) begin n_fail++; $display("FAIL full_wrap_count: got %b want 000", bus_b.count); end
    n_checks++;
    if (bus_b.wrap !== 1'b1) begin n_fail++; $display("FAIL full_wrap_pulse: got %b want 1", bus_b.wrap); end
    bus_b.up = 1'b0;
    step();
    n_checks++;
    if ($isunknown(bus_b.count) || bus_b.count !== 3'd7) begin n_fail++; $display("FAIL full_down_count: got %b want 111", bus_b.count); end
    n_checks++;
    if (bus_b.wrap !== 1'b1) begin n_fail++; $display("FAIL full_down_wrap: got %b want 1", bus_b.wrap); end
    bus_b.en = 1'b0; bus_b.load = 1'b1; bus_b.load_val = 3'd7; bus_b.up = 1'b1;
    step();
    n_checks++;
    if (bus_b.load_err !== 1'b0) begin n_fail++; $display("FAIL full_legal_load_err: got %b want 0", bus_b.load_err); end
    n_checks++;
    if (bus_b.wrap !== 1'b0) begin n_fail++; $display("FAIL full_load_wrap: got %b want 0", bus_b.wrap); end
    bus_b.load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_priority();
    test_illegal_load();
    test_dir_flip_hold();
    test_full_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
